// File: rtl/alarm_ringer_pkg.sv
// Shared types and default timing constants for the alarm ringer path.
// All durations are counted in cycles of the 1 Hz clock.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZED = 2'b10
    } ringer_state_e;

    localparam int RING_TIMEOUT_S = 60;
    localparam int SNOOZE_S       = 300;
    localparam int MAX_SNOOZES    = 3;
    localparam int BEEP_ON_S      = 1;
    localparam int BEEP_OFF_S     = 1;

endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm/button logic (master) and the ringer (slave).
// State is exported on `state` for observation by checkers.
interface alarm_ringer_if #(
    parameter int CNT_W = 2
);
    import alarm_pkg::*;

    // No valid/ready here: inputs are levels sampled every clock and edge-detected
    // by the ringer; outputs are registered and valid right after each clock edge.
    logic             alarm_trigger;
    logic             snooze_btn;
    logic             dismiss_btn;
    logic             ack_missed;
    logic             buzzer;
    logic             ringing;
    logic             snoozed;
    logic [CNT_W-1:0] snooze_count;
    logic [8:0]       snooze_remaining;
    logic             alarm_off_req;
    logic             missed_alarm;
    ringer_state_e    state;

    modport master (
        output alarm_trigger, snooze_btn, dismiss_btn, ack_missed,
        input  buzzer, ringing, snoozed, snooze_count, snooze_remaining,
               alarm_off_req, missed_alarm, state
    );

    modport slave (
        input  alarm_trigger, snooze_btn, dismiss_btn, ack_missed,
        output buzzer, ringing, snoozed, snooze_count, snooze_remaining,
               alarm_off_req, missed_alarm, state
    );

endinterface

// File: rtl/alarm_ringer_rise_detect.sv
// Rising-edge detector: one-cycle event when d_i goes from 0 to 1.
// Only the history bit is registered; the event is combinational from it.
module rise_detect (
    input  logic clk_1hz,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_1hz or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns a trigger edge into a beeping ring episode with snooze,
// dismiss and timeout handling, and reports the end of each episode.
module alarm_ringer #(
    parameter int RING_TIMEOUT_S = alarm_pkg::RING_TIMEOUT_S,
    parameter int SNOOZE_S       = alarm_pkg::SNOOZE_S,
    parameter int MAX_SNOOZES    = alarm_pkg::MAX_SNOOZES,
    parameter int BEEP_ON_S      = alarm_pkg::BEEP_ON_S,
    parameter int BEEP_OFF_S     = alarm_pkg::BEEP_OFF_S
) (
    input  logic          clk_1hz,
    input  logic          reset_n,
    alarm_ringer_if.slave bus
);

    localparam int CNT_W  = $clog2(MAX_SNOOZES + 1);
    localparam int RT_W   = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int BEEP_P = BEEP_ON_S + BEEP_OFF_S;
    localparam int PH_W   = (BEEP_P > 1) ? $clog2(BEEP_P) : 1;

    localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(RING_TIMEOUT_S - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BEEP_P - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SNOOZES);
    localparam logic [8:0]       SNZ_LOAD = 9'(SNOOZE_S);

    alarm_pkg::ringer_state_e state_q;
    logic [RT_W-1:0]  ring_timer_q, ring_timer_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] snooze_count_q;
    logic [8:0]       snooze_rem_q;
    logic             buzzer_q;
    logic             off_req_q;
    logic             missed_q;
    logic             trig_ev, snz_ev, dis_ev;

    rise_detect u_trig (.clk_1hz(clk_1hz), .reset_n(reset_n), .d_i(bus.alarm_trigger), .rise_o(trig_ev));
    rise_detect u_snz  (.clk_1hz(clk_1hz), .reset_n(reset_n), .d_i(bus.snooze_btn),    .rise_o(snz_ev));
    rise_detect u_dis  (.clk_1hz(clk_1hz), .reset_n(reset_n), .d_i(bus.dismiss_btn),   .rise_o(dis_ev));

    assign ring_timer_d = ring_timer_q + 1'b1;
    assign phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

    always_ff @(posedge clk_1hz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= alarm_pkg::IDLE;
            ring_timer_q   <= '0;
            phase_q        <= '0;
            snooze_count_q <= '0;
            snooze_rem_q   <= '0;
            buzzer_q       <= 1'b0;
            off_req_q      <= 1'b0;
            missed_q       <= 1'b0;
        end else begin
            off_req_q <= 1'b0;
            // A timeout set later in this block overrides the acknowledge.
            if (bus.ack_missed) missed_q <= 1'b0;
            case (state_q)
                alarm_pkg::IDLE: begin
                    if (trig_ev) begin
                        state_q      <= alarm_pkg::RINGING;
                        ring_timer_q <= '0;
                        phase_q      <= '0;
                        buzzer_q     <= 1'b1;
                    end
                end
                alarm_pkg::RINGING: begin
                    if (dis_ev) begin
                        state_q        <= alarm_pkg::IDLE;
                        off_req_q      <= 1'b1;
                        buzzer_q       <= 1'b0;
                        snooze_count_q <= '0;
                    end else if (snz_ev && (snooze_count_q < CNT_MAX)) begin
                        state_q        <= alarm_pkg::SNOOZED;
                        snooze_count_q <= snooze_count_q + 1'b1;
                        snooze_rem_q   <= SNZ_LOAD;
                        buzzer_q       <= 1'b0;
                    end else if (ring_timer_q == RT_LAST) begin
                        state_q        <= alarm_pkg::IDLE;
                        off_req_q      <= 1'b1;
                        buzzer_q       <= 1'b0;
                        snooze_count_q <= '0;
                        missed_q       <= 1'b1;
                    end else begin
                        ring_timer_q <= ring_timer_d;
                        phase_q      <= phase_d;
                        buzzer_q     <= (32'(phase_d) < BEEP_ON_S);
                    end
                end
                alarm_pkg::SNOOZED: begin
                    if (dis_ev) begin
                        state_q        <= alarm_pkg::IDLE;
                        off_req_q      <= 1'b1;
                        snooze_rem_q   <= '0;
                        snooze_count_q <= '0;
                    end else if (snooze_rem_q == 9'd1) begin
                        state_q      <= alarm_pkg::RINGING;
                        ring_timer_q <= '0;
                        phase_q      <= '0;
                        buzzer_q     <= 1'b1;
                        snooze_rem_q <= '0;
                    end else begin
                        snooze_rem_q <= snooze_rem_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= alarm_pkg::IDLE;
                end
            endcase
        end
    end

    assign bus.buzzer           = buzzer_q;
    assign bus.ringing          = (state_q == alarm_pkg::RINGING);
    assign bus.snoozed          = (state_q == alarm_pkg::SNOOZED);
    assign bus.snooze_count     = snooze_count_q;
    assign bus.snooze_remaining = snooze_rem_q;
    assign bus.alarm_off_req    = off_req_q;
    assign bus.missed_alarm     = missed_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios plus random button traffic,
// checked against a cycle-level behavioural model of the ringer rules.
module tb_alarm_ringer;
    import alarm_pkg::*;

    localparam int T_RING = 10;
    localparam int T_SNZ  = 5;
    localparam int N_SNZ  = 2;
    localparam int B_ON   = 1;
    localparam int B_OFF  = 1;
    localparam int CW     = $clog2(N_SNZ + 1);
    localparam int W      = 5 + CW + 9;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk_1hz = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    alarm_ringer_if #(.CNT_W(CW)) bus ();

    alarm_ringer #(
        .RING_TIMEOUT_S(T_RING), .SNOOZE_S(T_SNZ), .MAX_SNOOZES(N_SNZ),
        .BEEP_ON_S(B_ON), .BEEP_OFF_S(B_OFF)
    ) dut (
        .clk_1hz(clk_1hz),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: mode, time since ring start, snooze time left
    int m_mode, m_age, m_left, m_count;
    bit m_off, m_missed;
    bit p_t, p_s, p_d;

    function automatic logic [W-1:0] dut_vec();
        return {bus.buzzer, bus.ringing, bus.snoozed, bus.snooze_count,
                bus.snooze_remaining, bus.alarm_off_req, bus.missed_alarm};
    endfunction

    function automatic logic [W-1:0] mdl_vec();
        logic ring, buz, snz;
        ring = (m_mode == M_RING);
        snz  = (m_mode == M_SNZ);
        buz  = ring && ((m_age % (B_ON + B_OFF)) < B_ON);
        return {buz, ring, snz, CW'(m_count), 9'(m_left), m_off, m_missed};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_left = 0; m_count = 0;
        m_off = 0; m_missed = 0; p_t = 0; p_s = 0; p_d = 0;
    endtask

    task automatic step(input bit [3:0] tsda);
        bit t, s, d, a, te, se, de, set_m;
        {t, s, d, a} = tsda;
        @(negedge clk_1hz);
        bus.alarm_trigger = t; bus.snooze_btn = s; bus.dismiss_btn = d; bus.ack_missed = a;
        te = t && !p_t; se = s && !p_s; de = d && !p_d;
        p_t = t; p_s = s; p_d = d;
        m_off = 0; set_m = 0;
        case (m_mode)
            M_IDLE: if (te) begin m_mode = M_RING; m_age = 0; end
            M_RING: begin
                if (de) begin
                    m_mode = M_IDLE; m_off = 1; m_count = 0;
                end else if (se && m_count < N_SNZ) begin
                    m_mode = M_SNZ; m_count++; m_left = T_SNZ;
                end else if (m_age == T_RING - 1) begin
                    m_mode = M_IDLE; m_off = 1; m_count = 0; set_m = 1;
                end else begin
                    m_age++;
                end
            end
            M_SNZ: begin
                if (de) begin
                    m_mode = M_IDLE; m_off = 1; m_count = 0; m_left = 0;
                end else if (m_left == 1) begin
                    m_mode = M_RING; m_age = 0; m_left = 0;
                end else begin
                    m_left--;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        if (set_m) m_missed = 1;
        else if (a) m_missed = 0;
        exp_q.push_back(mdl_vec());
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic test_reset();
        bus.alarm_trigger = 0; bus.snooze_btn = 0; bus.dismiss_btn = 0; bus.ack_missed = 0;
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk_1hz);
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        checks++;
        if (bus.state !== IDLE) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE);
        end
        @(negedge clk_1hz);
        reset_n = 1;
    endtask

    task automatic test_dismiss();
        bit [3:0] seq[6];
        bit exp_buz[6], exp_off[6];
        logic [W-1:0] e;
        seq     = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1000, 4'b0000};
        exp_buz = '{1, 0, 1, 0, 0, 0};
        exp_off = '{0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL dismiss_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
            checks++;
            if (bus.buzzer !== exp_buz[i] || bus.alarm_off_req !== exp_off[i]) begin
                failures++;
                $display("FAIL dismiss_pattern cyc=%0d buzzer=%b off=%b exp buzzer=%b off=%b",
                         i, bus.buzzer, bus.alarm_off_req, exp_buz[i], exp_off[i]);
            end
        end
    endtask

    task automatic test_snooze_rering();
        bit [3:0] seq[10];
        logic [W-1:0] e;
        seq = '{4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            step(seq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL snooze_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
            if (i >= 2 && i <= 6) begin
                checks++;
                if (bus.snoozed !== 1'b1 || bus.snooze_count !== CW'(1) ||
                    bus.snooze_remaining !== 9'(7 - i) || bus.buzzer !== 1'b0) begin
                    failures++;
                    $display("FAIL snooze_count_down cyc=%0d snz=%b cnt=%0d rem=%0d buz=%b exp rem=%0d",
                             i, bus.snoozed, bus.snooze_count, bus.snooze_remaining, bus.buzzer, 7 - i);
                end
            end
            if (i == 7) begin
                checks++;
                if (bus.ringing !== 1'b1 || bus.buzzer !== 1'b1 || bus.snooze_remaining !== 9'd0) begin
                    failures++;
                    $display("FAIL snooze_rering ring=%b buz=%b rem=%0d exp 1 1 0",
                             bus.ringing, bus.buzzer, bus.snooze_remaining);
                end
            end
        end
    endtask

    task automatic test_snooze_limit();
        bit [3:0] sq[$];
        logic [W-1:0] e;
        int offs;
        sq.push_back(4'b1000);
        for (int k = 0; k < 2; k++) begin
            sq.push_back(4'b0100);
            repeat (T_SNZ) sq.push_back(4'b0000);
        end
        sq.push_back(4'b0100);
        repeat (T_RING + 1) sq.push_back(4'b0000);
        offs = 0;
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL limit_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
            if (bus.alarm_off_req === 1'b1) offs++;
            if (i == 2 * (T_SNZ + 1) + 1) begin
                checks++;
                if (bus.ringing !== 1'b1 || bus.snooze_count !== CW'(2)) begin
                    failures++;
                    $display("FAIL limit_third_snooze ring=%b cnt=%0d exp 1 2", bus.ringing, bus.snooze_count);
                end
            end
        end
        checks++;
        if (bus.missed_alarm !== 1'b1 || bus.snooze_count !== '0 || offs != 1 || bus.ringing !== 1'b0) begin
            failures++;
            $display("FAIL limit_timeout missed=%b cnt=%0d offs=%0d ring=%b exp 1 0 1 0",
                     bus.missed_alarm, bus.snooze_count, offs, bus.ringing);
        end
    endtask

    task automatic test_ack();
        bit [3:0] sq[$];
        logic [W-1:0] e;
        int rings;
        sq.push_back(4'b1000); sq.push_back(4'b1000); sq.push_back(4'b1010);
        repeat (20) sq.push_back(4'b1000);
        sq.push_back(4'b0001); sq.push_back(4'b0000);
        rings = 0;
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL ack_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
            if (i >= 3 && i < 23 && bus.ringing === 1'b1) rings++;
            if (i == 22) begin
                checks++;
                if (rings != 0 || bus.missed_alarm !== 1'b1) begin
                    failures++;
                    $display("FAIL ack_no_rering rings=%0d missed=%b exp 0 1", rings, bus.missed_alarm);
                end
            end
        end
        checks++;
        if (bus.missed_alarm !== 1'b0) begin
            failures++; $display("FAIL ack_clear got=%b exp=0", bus.missed_alarm);
        end
    endtask

    task automatic test_simultaneous();
        bit [3:0] sq[$];
        logic [W-1:0] e;
        sq.push_back(4'b1000); sq.push_back(4'b0100);
        repeat (T_SNZ) sq.push_back(4'b0000);
        sq.push_back(4'b0000); sq.push_back(4'b0110); sq.push_back(4'b0000);
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL simul_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
            if (i == sq.size() - 2) begin
                checks++;
                if (bus.ringing !== 1'b0 || bus.snoozed !== 1'b0 || bus.alarm_off_req !== 1'b1 ||
                    bus.snooze_count !== '0) begin
                    failures++;
                    $display("FAIL simul_dismiss_wins ring=%b snz=%b off=%b cnt=%0d exp 0 0 1 0",
                             bus.ringing, bus.snoozed, bus.alarm_off_req, bus.snooze_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid_snooze();
        logic [W-1:0] e;
        bit [3:0] seq[4];
        seq = '{4'b1000, 4'b0100, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            step(seq[i]);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL rst_mid_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
        end
        #2;
        bus.alarm_trigger = 0; bus.snooze_btn = 0; bus.dismiss_btn = 0; bus.ack_missed = 0;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL rst_mid_immediate got=%h exp=0", dut_vec());
        end
        @(posedge clk_1hz);
        #1;
        checks++;
        if (bus.alarm_off_req !== 1'b0 || dut_vec() !== '0) begin
            failures++; $display("FAIL rst_mid_hold got=%h exp=0", dut_vec());
        end
        @(negedge clk_1hz);
        reset_n = 1;
        step(4'b1000);
        e = exp_q.pop_front();
        checks++;
        if (dut_vec() !== e || bus.ringing !== 1'b1 || bus.buzzer !== 1'b1) begin
            failures++; $display("FAIL rst_mid_rering got=%h exp=%h", dut_vec(), e);
        end
        step(4'b0010);
        e = exp_q.pop_front();
        checks++;
        if (dut_vec() !== e) begin
            failures++; $display("FAIL rst_mid_dismiss got=%h exp=%h", dut_vec(), e);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        bit t, s, d, a;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) t = ~t;
            s = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 15) == 0);
            step({t, s, d, a});
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
                failures++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, dut_vec(), e);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dismiss();
        test_snooze_rering();
        test_snooze_limit();
        test_ack();
        test_simultaneous();
        test_reset_mid_snooze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
